// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - memory opcodes, access decode and byte-lane select helpers
package mem_pkg;

  // Memory opcodes carried on ex_aluop; anything else is a non-memory op.
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_LL  = 8'hF0;
  localparam logic [7:0] OP_SC  = 8'hF8;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } mem_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_store;
    mem_size_e size;
  } mem_dec_t;

  // Classify an opcode by whether it touches memory, direction and width.
  function automatic mem_dec_t mem_decode(input logic [7:0] op);
    mem_dec_t d;
    d = '{is_mem: 1'b0, is_store: 1'b0, size: SZ_NONE};
    case (op)
      OP_LB, OP_LBU:        d = '{is_mem: 1'b1, is_store: 1'b0, size: SZ_BYTE};
      OP_LH, OP_LHU:        d = '{is_mem: 1'b1, is_store: 1'b0, size: SZ_HALF};
      OP_LW, OP_LL:         d = '{is_mem: 1'b1, is_store: 1'b0, size: SZ_WORD};
      OP_SB:                d = '{is_mem: 1'b1, is_store: 1'b1, size: SZ_BYTE};
      OP_SH:                d = '{is_mem: 1'b1, is_store: 1'b1, size: SZ_HALF};
      OP_SW, OP_SC:         d = '{is_mem: 1'b1, is_store: 1'b1, size: SZ_WORD};
      default:              d = '{is_mem: 1'b0, is_store: 1'b0, size: SZ_NONE};
    endcase
    return d;
  endfunction

  // Little-endian lane select: byte k -> bit k, half h -> lanes 2h and 2h+1.
  function automatic logic [3:0] sel_gen(input mem_size_e size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      SZ_BYTE: s = 4'b0001 << off;
      SZ_HALF: s = 4'b0011 << {off[1], 1'b0};
      SZ_WORD: s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/llbit_reg.sv
// rtl/llbit_reg.sv - LL/SC reservation bit and linked word address
module llbit_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ll_set,
  input  logic        ll_clr,
  input  logic [29:0] addr_word,
  output logic        llbit,
  output logic [29:0] link_addr
);

  // Reservation bit: flush always kills it, then reset, then SC/store clear beats LL set.
  always_ff @(posedge clk) begin
    if (flush) begin
      llbit <= 1'b0;
    end else if (rst) begin
      llbit <= 1'b0;
    end else if (!stall) begin
      if (ll_clr) begin
        llbit <= 1'b0;
      end else if (ll_set) begin
        llbit <= 1'b1;
      end
    end
  end

  // Linked word address is captured only by an LL that actually takes effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_addr <= '0;
    end else if (!stall && !flush && ll_set && !ll_clr) begin
      link_addr <= addr_word;
    end
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: RAM lane control, load extension, LL/SC, MEM/WB register
module mem_access
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [7:0]  ex_aluop,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        misalign_o,
  output logic        llbit_o
);

  mem_dec_t    dec;
  logic [1:0]  off;
  logic [29:0] addr_word;
  logic        misalign;
  logic        access;
  logic        is_ll;
  logic        is_sc;
  logic        llbit;
  logic [29:0] link_addr;
  logic        link_match;
  logic        sc_ok;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] result;

  assign dec        = mem_decode(ex_aluop);
  assign off        = ex_mem_addr[1:0];
  assign addr_word  = ex_mem_addr[31:2];
  assign is_ll      = (ex_aluop == OP_LL);
  assign is_sc      = (ex_aluop == OP_SC);
  assign link_match = (addr_word == link_addr);
  assign sc_ok      = llbit & link_match;
  assign access     = dec.is_mem & ~misalign;
  assign misalign_o = misalign;
  assign llbit_o    = llbit;

  // Halfwords must be 2-byte aligned, words (incl. LL/SC) 4-byte aligned.
  always_comb begin
    misalign = 1'b0;
    case (dec.size)
      SZ_HALF: misalign = ex_mem_addr[0];
      SZ_WORD: misalign = |ex_mem_addr[1:0];
      default: misalign = 1'b0;
    endcase
  end

  // RAM request; everything reads zero when no aligned access is in flight.
  always_comb begin
    ram_ce     = access;
    ram_we     = access & dec.is_store & ~stall & ~flush & (~is_sc | sc_ok);
    ram_sel    = 4'b0000;
    ram_addr   = 32'h0;
    ram_data_o = 32'h0;
    if (access) begin
      ram_sel  = sel_gen(dec.size, off);
      ram_addr = {addr_word, 2'b00};
      if (dec.is_store) begin
        case (dec.size)
          SZ_BYTE: ram_data_o = {4{ex_reg2[7:0]}};
          SZ_HALF: ram_data_o = {2{ex_reg2[15:0]}};
          default: ram_data_o = ex_reg2;
        endcase
      end
    end
  end

  // Pick the addressed byte and halfword out of the read word.
  always_comb begin
    load_byte = ram_data_i[7:0];
    case (off)
      2'd0:    load_byte = ram_data_i[7:0];
      2'd1:    load_byte = ram_data_i[15:8];
      2'd2:    load_byte = ram_data_i[23:16];
      default: load_byte = ram_data_i[31:24];
    endcase
    load_half = off[1] ? ram_data_i[31:16] : ram_data_i[15:0];
  end

  // Write-back value: extended load data, SC success flag, or the ALU result.
  always_comb begin
    result = ex_wdata;
    case (ex_aluop)
      OP_LB:        result = {{24{load_byte[7]}}, load_byte};
      OP_LBU:       result = {24'h0, load_byte};
      OP_LH:        result = {{16{load_half[15]}}, load_half};
      OP_LHU:       result = {16'h0, load_half};
      OP_LW, OP_LL: result = ram_data_i;
      OP_SC:        result = {31'h0, sc_ok};
      default:      result = ex_wdata;
    endcase
  end

  // MEM/WB register: flush injects a bubble, stall holds, misaligned ops never write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wd    <= '0;
      wb_wreg  <= 1'b0;
      wb_wdata <= '0;
    end else if (flush) begin
      wb_wd    <= '0;
      wb_wreg  <= 1'b0;
      wb_wdata <= '0;
    end else if (!stall) begin
      wb_wd    <= ex_wd;
      wb_wreg  <= ex_wreg & ~misalign;
      wb_wdata <= result;
    end
  end

  // Any aligned SC, or a plain store hitting the linked word, breaks the reservation.
  llbit_reg u_llbit (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .ll_set    (is_ll & ~misalign),
    .ll_clr    (~misalign & (is_sc | (dec.is_store & link_match))),
    .addr_word (addr_word),
    .llbit     (llbit),
    .link_addr (link_addr)
  );

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a behavioural model
module tb_mem_access;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [7:0]  ex_aluop;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic        ram_ce;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        misalign_o;
  logic        llbit_o;

  always #5 clk = ~clk;

  mem_access dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .ex_aluop    (ex_aluop),
    .ex_wd       (ex_wd),
    .ex_wreg     (ex_wreg),
    .ex_wdata    (ex_wdata),
    .ex_mem_addr (ex_mem_addr),
    .ex_reg2     (ex_reg2),
    .ram_ce      (ram_ce),
    .ram_we      (ram_we),
    .ram_sel     (ram_sel),
    .ram_addr    (ram_addr),
    .ram_data_o  (ram_data_o),
    .ram_data_i  (ram_data_i),
    .wb_wd       (wb_wd),
    .wb_wreg     (wb_wreg),
    .wb_wdata    (wb_wdata),
    .misalign_o  (misalign_o),
    .llbit_o     (llbit_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // RAM seen by the DUT (written from its ram_* outputs) and the model's own copy.
  logic [31:0] dut_mem   [16];
  logic [31:0] model_mem [16];
  int          dut_writes;

  function automatic logic [31:0] init_val(input int i);
    return (i * 32'h01010101) ^ 32'h5A3C0F00;
  endfunction

  assign ram_data_i = dut_mem[ex_mem_addr[5:2]];

  // Byte-banked RAM: each selected lane captures its byte on the write edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) dut_mem[i] <= init_val(i);
      dut_writes <= 0;
    end else if (ram_we) begin
      for (int k = 0; k < 4; k++)
        if (ram_sel[k]) dut_mem[ram_addr[5:2]][8*k +: 8] <= ram_data_o[8*k +: 8];
      dut_writes <= dut_writes + 1;
    end
  end

  // Architectural state of the reference model.
  logic        m_ll;
  logic [29:0] m_link;
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One instruction in MEM for one cycle: check the RAM request, advance the model, check WB/LL.
  task automatic step(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                      input logic [31:0] wdata, input logic [31:0] addr,
                      input logic [31:0] reg2, input logic st, input logic fl);
    logic        is_b, is_h, is_w, is_ld, is_st, mis, ok, hit, sc_ok, e_we;
    logic [31:0] word, res;
    logic [7:0]  b;
    logic [15:0] h;
    logic [3:0]  e_sel;
    logic [31:0] e_dout;
    int          idx;
    ex_aluop = op; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_mem_addr = addr; ex_reg2 = reg2; stall = st; flush = fl;
    #1;
    is_b  = op inside {OP_LB, OP_LBU, OP_SB};
    is_h  = op inside {OP_LH, OP_LHU, OP_SH};
    is_w  = op inside {OP_LW, OP_LL, OP_SW, OP_SC};
    is_ld = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL};
    is_st = op inside {OP_SB, OP_SH, OP_SW, OP_SC};
    mis   = (is_h && addr[0]) || (is_w && addr[1:0] != 2'b00);
    ok    = (is_ld || is_st) && !mis;
    idx   = int'(addr[5:2]);
    word  = model_mem[idx];
    hit   = (m_link == addr[31:2]);
    sc_ok = m_ll && hit;
    e_we  = is_st && ok && !st && !fl && (op != OP_SC || sc_ok);

    check("misalign", {31'h0, misalign_o}, {31'h0, mis});
    check("ram_ce", {31'h0, ram_ce}, {31'h0, ok});
    check("ram_we", {31'h0, ram_we}, {31'h0, e_we});
    if (ok) begin
      e_sel = is_b ? (4'b0001 << addr[1:0]) : is_h ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      check("ram_addr", ram_addr, {addr[31:2], 2'b00});
      check("ram_sel", {28'h0, ram_sel}, {28'h0, e_sel});
    end
    if (e_we) begin
      e_dout = is_b ? {4{reg2[7:0]}} : is_h ? {2{reg2[15:0]}} : reg2;
      check("ram_data_o", ram_data_o, e_dout);
    end

    b = word[8*addr[1:0] +: 8];
    h = word[16*addr[1] +: 16];
    case (op)
      OP_LB:        res = 32'($signed(b));
      OP_LBU:       res = 32'(b);
      OP_LH:        res = 32'($signed(h));
      OP_LHU:       res = 32'(h);
      OP_LW, OP_LL: res = word;
      OP_SC:        res = sc_ok ? 32'd1 : 32'd0;
      default:      res = wdata;
    endcase

    @(posedge clk);
    if (e_we) begin
      if (is_b)      model_mem[idx][8*addr[1:0] +: 8] = reg2[7:0];
      else if (is_h) model_mem[idx][16*addr[1] +: 16] = reg2[15:0];
      else           model_mem[idx] = reg2;
    end
    if (fl) begin
      m_wd = 0; m_wreg = 0; m_wdata = 0;
    end else if (!st) begin
      m_wd = wd; m_wreg = wreg && !mis; m_wdata = res;
    end
    if (fl) begin
      m_ll = 0;
    end else if (!st && ok) begin
      if (op == OP_SC || (is_st && hit)) m_ll = 0;
      else if (op == OP_LL) begin
        m_ll = 1;
        m_link = addr[31:2];
      end
    end
    #1;
    check("wb_wreg", {31'h0, wb_wreg}, {31'h0, m_wreg});
    check("wb_wd", {27'h0, wb_wd}, {27'h0, m_wd});
    if (m_wreg) check("wb_wdata", wb_wdata, m_wdata);
    check("llbit", {31'h0, llbit_o}, {31'h0, m_ll});
  endtask

  logic [7:0] op_tab [11];
  int         w0;

  initial begin
    op_tab = '{OP_NOP, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_SB, OP_SH, OP_SW, OP_SC};
    for (int i = 0; i < 16; i++) model_mem[i] = init_val(i);
    m_ll = 0; m_link = 0; m_wd = 0; m_wreg = 0; m_wdata = 0;

    rst = 1; stall = 0; flush = 0;
    ex_aluop = OP_NOP; ex_wd = 0; ex_wreg = 0; ex_wdata = 0; ex_mem_addr = 0; ex_reg2 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_wd", {27'h0, wb_wd}, 32'h0);
    check("rst_wb_wreg", {31'h0, wb_wreg}, 32'h0);
    check("rst_wb_wdata", wb_wdata, 32'h0);
    check("rst_llbit", {31'h0, llbit_o}, 32'h0);
    check("rst_ram_ce", {31'h0, ram_ce}, 32'h0);
    check("rst_ram_sel", {28'h0, ram_sel}, 32'h0);
    check("rst_ram_data_o", ram_data_o, 32'h0);
    rst = 0;

    // LL then SC to the same word succeeds.
    step(OP_LL, 5'd1, 1, 0, 32'h0, 0, 0, 0);
    step(OP_SC, 5'd3, 1, 0, 32'h0, 32'h0000_1234, 0, 0);
    check("llsc_rd", wb_wdata, 32'd1);
    check("llsc_mem", dut_mem[0], 32'h0000_1234);
    check("llsc_llbit", {31'h0, llbit_o}, 32'h0);

    // Intervening store to the linked word kills the SC.
    step(OP_LL, 5'd1, 1, 0, 32'h4, 0, 0, 0);
    step(OP_SW, 5'd0, 0, 0, 32'h4, 32'hDEAD_BEEF, 0, 0);
    step(OP_SC, 5'd3, 1, 0, 32'h4, 32'h55, 0, 0);
    check("sw_kill_rd", wb_wdata, 32'd0);
    check("sw_kill_mem", dut_mem[1], 32'hDEAD_BEEF);

    // Flush between LL and SC kills the SC.
    step(OP_LL, 5'd1, 1, 0, 32'h8, 0, 0, 0);
    step(OP_NOP, 5'd0, 0, 0, 32'h0, 0, 0, 1);
    step(OP_SC, 5'd3, 1, 0, 32'h8, 32'h77, 0, 0);
    check("flush_kill_rd", wb_wdata, 32'd0);
    check("flush_kill_mem", dut_mem[2], init_val(2));

    // A store to a different word leaves the reservation alone.
    step(OP_LL, 5'd1, 1, 0, 32'h8, 0, 0, 0);
    step(OP_SW, 5'd0, 0, 0, 32'h0, 32'h0, 0, 0);
    step(OP_SC, 5'd3, 1, 0, 32'h8, 32'h99, 0, 0);
    check("other_word_rd", wb_wdata, 32'd1);

    // Byte store lane/replication, then signed and unsigned byte loads.
    step(OP_SB, 5'd0, 0, 0, 32'h1, 32'h0000_00AB, 0, 0);
    check("sb_mem", dut_mem[0], 32'h0000_AB00);
    step(OP_LB, 5'd5, 1, 0, 32'h1, 0, 0, 0);
    check("lb_sext", wb_wdata, 32'hFFFF_FFAB);
    step(OP_LBU, 5'd6, 1, 0, 32'h1, 0, 0, 0);
    check("lbu_zext", wb_wdata, 32'h0000_00AB);

    // Misaligned word load never writes back.
    step(OP_LW, 5'd7, 1, 0, 32'h2, 0, 0, 0);
    check("lw_mis_wreg", {31'h0, wb_wreg}, 32'h0);

    // SC held by stall for three cycles writes exactly once.
    step(OP_LL, 5'd1, 1, 0, 32'hC, 0, 0, 0);
    w0 = dut_writes;
    repeat (3) step(OP_SC, 5'd3, 1, 0, 32'hC, 32'hCAFE_0001, 1, 0);
    step(OP_SC, 5'd3, 1, 0, 32'hC, 32'hCAFE_0001, 0, 0);
    check("stall_writes", dut_writes - w0, 32'd1);
    check("stall_rd", wb_wdata, 32'd1);
    check("stall_mem", dut_mem[3], 32'hCAFE_0001);

    // Randomized traffic biased towards aligned accesses and linked-word SCs.
    for (int n = 0; n < 600; n++) begin
      logic [7:0]  op;
      logic [31:0] a;
      op = op_tab[$urandom_range(0, 10)];
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (op inside {OP_LH, OP_LHU, OP_SH}) a[0] = 1'b0;
        else if (op inside {OP_LW, OP_LL, OP_SW, OP_SC}) a[1:0] = 2'b00;
      end
      if (op == OP_SC && $urandom_range(0, 1) == 1) a = {m_link, 2'b00};
      step(op, 5'($urandom), 1'($urandom), $urandom, a, $urandom,
           $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    end

    for (int i = 0; i < 16; i++) check("final_mem", dut_mem[i], model_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
